// File: rtl/present_pkg.sv
// Shared types, constants and PRESENT-80 primitives for the iterative decryption core.
package present_pkg;

    localparam logic [4:0] ROUNDS = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEXP   = 3'd1,
        ST_WHITEN = 3'd2,
        ST_DEC    = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0:    y = 4'hC;
            4'h1:    y = 4'h5;
            4'h2:    y = 4'h6;
            4'h3:    y = 4'hB;
            4'h4:    y = 4'h9;
            4'h5:    y = 4'h0;
            4'h6:    y = 4'hA;
            4'h7:    y = 4'hD;
            4'h8:    y = 4'h3;
            4'h9:    y = 4'hE;
            4'hA:    y = 4'hF;
            4'hB:    y = 4'h8;
            4'hC:    y = 4'h4;
            4'hD:    y = 4'h7;
            4'hE:    y = 4'h1;
            4'hF:    y = 4'h2;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0:    y = 4'h5;
            4'h1:    y = 4'hE;
            4'h2:    y = 4'hF;
            4'h3:    y = 4'h8;
            4'h4:    y = 4'hC;
            4'h5:    y = 4'h1;
            4'h6:    y = 4'h2;
            4'h7:    y = 4'hD;
            4'h8:    y = 4'hB;
            4'h9:    y = 4'h4;
            4'hA:    y = 4'h6;
            4'hB:    y = 4'h3;
            4'hC:    y = 4'h0;
            4'hD:    y = 4'h7;
            4'hE:    y = 4'h9;
            4'hF:    y = 4'hA;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    // Bit i of the result is gathered from where the forward pLayer would have sent it.
    function automatic logic [63:0] perm_inv(input logic [63:0] x);
        logic [63:0] r;
        logic [5:0]  src;
        r = 64'd0;
        for (int i = 0; i < 63; i++) begin
            src  = 6'((i * 16) % 63);
            r[i] = x[src];
        end
        r[63] = x[63];
        return r;
    endfunction

    function automatic logic [79:0] key_fwd(input logic [79:0] key, input logic [4:0] c);
        logic [79:0] t;
        t          = {key[18:0], key[79:19]};
        t[79:76]   = sbox(t[79:76]);
        t[19:15]   = t[19:15] ^ c;
        return t;
    endfunction

    function automatic logic [79:0] key_inv(input logic [79:0] key, input logic [4:0] c);
        logic [79:0] t;
        t          = key;
        t[19:15]   = t[19:15] ^ c;
        t[79:76]   = sbox_inv(t[79:76]);
        return {t[60:0], t[79:61]};
    endfunction

endpackage

// File: rtl/present_dec_round.sv
// One inverse PRESENT round: steps the key schedule back by one and unwinds the state.
module present_dec_round
    import present_pkg::*;
(
    input  logic [63:0] st_i,
    input  logic [79:0] key_i,
    input  logic [4:0]  cnt_i,
    output logic [63:0] st_o,
    output logic [79:0] key_o
);

    logic [63:0] perm_s;
    logic [63:0] sub_s;

    // Inverse pLayer, inverse S-box layer, then add the recovered round key.
    always_comb begin
        key_o  = key_inv(key_i, cnt_i);
        perm_s = perm_inv(st_i);
        sub_s  = 64'd0;
        for (int i = 0; i < 16; i++) begin
            sub_s[4*i +: 4] = sbox_inv(perm_s[4*i +: 4]);
        end
        st_o = sub_s ^ key_o[79:16];
    end

endmodule

// File: rtl/present_dec_iter.sv
// Iterative PRESENT-80 decryption: forward key expansion, whitening, then 31 inverse rounds.
module present_dec_iter
    import present_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] ct,
    input  logic [79:0] k,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] pt
);

    state_e      state_q;
    logic [63:0] st_q;
    logic [79:0] key_q;
    logic [4:0]  cnt_q;
    logic [63:0] pt_q;
    logic [63:0] st_d;
    logic [79:0] key_d;

    present_dec_round u_round (
        .st_i  (st_q),
        .key_i (key_q),
        .cnt_i (cnt_q),
        .st_o  (st_d),
        .key_o (key_d)
    );

    // Handshake flags are pure state decodes so they never depend on inputs.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign pt        = pt_q;

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            st_q    <= 64'd0;
            key_q   <= 80'd0;
            cnt_q   <= 5'd0;
            pt_q    <= 64'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        st_q    <= ct;
                        key_q   <= k;
                        cnt_q   <= 5'd1;
                        state_q <= ST_KEXP;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_KEXP: begin
                    key_q <= key_fwd(key_q, cnt_q);
                    // Last step yields K32; cnt stays at 31 to seed the first inverse round.
                    if (cnt_q == ROUNDS) begin
                        cnt_q   <= ROUNDS;
                        state_q <= ST_WHITEN;
                    end else begin
                        cnt_q   <= cnt_q + 5'd1;
                    end
                end
                ST_WHITEN: begin
                    st_q    <= st_q ^ key_q[79:16];
                    state_q <= ST_DEC;
                end
                ST_DEC: begin
                    st_q  <= st_d;
                    key_q <= key_d;
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        pt_q    <= st_d;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_DEC;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_present_dec_iter.sv
// Directed known-answer bench for present_dec_iter with handshake corner-case sequences.
module tb_present_dec_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] ct;
    logic [79:0] k;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] pt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    typedef struct {
        logic [63:0] ct;
        logic [79:0] k;
        logic [63:0] pt;
    } vec_t;

    vec_t vecs [4];

    present_dec_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct        (ct),
        .k         (k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt        (pt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic start_job(input logic [63:0] c, input logic [79:0] kk);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {79'd0, in_ready}, 80'd1);
        in_valid = 1'b1;
        ct       = c;
        k        = kk;
        @(posedge clk);
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [63:0] exp);
        int   n;
        logic busy_bad;
        n        = 0;
        busy_bad = 1'b0;
        while (!out_valid && n < 200) begin
            if (in_ready) busy_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, {79'd0, out_valid}, 80'd1);
        check({name, "_latency"}, 80'(cyc - acc_cyc), 80'd63);
        check({name, "_pt"}, {16'd0, pt}, {16'd0, exp});
        check({name, "_busy_ready"}, {79'd0, busy_bad}, 80'd0);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", {79'd0, out_valid}, 80'd0);
        check("release_ready", {79'd0, in_ready}, 80'd1);
    endtask

    initial begin
        logic [95:0] r;
        logic        bad;
        logic [63:0] held;
        int          n;

        vecs[0] = '{64'h5579C1387B228445, 80'h0, 64'h0};
        vecs[1] = '{64'hE72C46C0F5945049, {80{1'b1}}, 64'h0};
        vecs[2] = '{64'hA112FFC72F68417B, 80'h0, {64{1'b1}}};
        vecs[3] = '{64'h3333DCD3213210D2, {80{1'b1}}, {64{1'b1}}};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ct        = 64'd0;
        k         = 80'd0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {79'd0, in_ready}, 80'd1);
        check("rst_out_valid", {79'd0, out_valid}, 80'd0);
        check("rst_pt", {16'd0, pt}, 80'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_in_ready", {79'd0, in_ready}, 80'd1);
        check("idle_out_valid", {79'd0, out_valid}, 80'd0);
        check("idle_pt", {16'd0, pt}, 80'd0);

        for (int v = 0; v < 4; v++) begin
            start_job(vecs[v].ct, vecs[v].k);
            wait_done($sformatf("kat%0d", v), vecs[v].pt);
            release_out();
        end

        // Backpressure: result must sit still while the consumer stalls.
        start_job(vecs[2].ct, vecs[2].k);
        wait_done("bp", vecs[2].pt);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!out_valid || pt !== vecs[2].pt) bad = 1'b1;
        end
        check("bp_stable", {79'd0, bad}, 80'd0);
        release_out();
        check("bp_pt_kept", {16'd0, pt}, {16'd0, vecs[2].pt});

        // Busy rejection: noise on the input side during DEC.
        start_job(vecs[1].ct, vecs[1].k);
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) bad = 1'b1;
            if (i >= 33) begin
                r        = {$urandom, $urandom, $urandom};
                in_valid = i[0];
                ct       = r[63:0];
                k        = r[79:0];
            end
        end
        in_valid = 1'b0;
        check("busy_ready_low", {79'd0, bad}, 80'd0);
        wait_done("busy", vecs[1].pt);
        release_out();

        // Back-to-back: in_valid held high across two jobs.
        in_valid  = 1'b1;
        ct        = vecs[0].ct;
        k         = vecs[0].k;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        ct      = vecs[2].ct;
        k       = vecs[2].k;
        wait_done("b2b_a", vecs[0].pt);
        @(posedge clk);
        @(negedge clk);
        check("b2b_gap_valid", {79'd0, out_valid}, 80'd0);
        check("b2b_gap_ready", {79'd0, in_ready}, 80'd1);
        @(posedge clk);
        @(negedge clk);
        acc_cyc   = cyc;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_second_accepted", {79'd0, in_ready}, 80'd0);
        wait_done("b2b_b", vecs[2].pt);
        held = pt;
        release_out();
        check("b2b_pt_nonzero_before_rst", {16'd0, held}, {16'd0, vecs[2].pt});

        // Mid-job reset while in DEC.
        start_job(vecs[1].ct, vecs[1].k);
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", {79'd0, in_ready}, 80'd1);
        check("mid_rst_out_valid", {79'd0, out_valid}, 80'd0);
        check("mid_rst_pt", {16'd0, pt}, 80'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        n   = 0;
        while (n < 70) begin
            @(negedge clk);
            if (out_valid || !in_ready) bad = 1'b1;
            n++;
        end
        check("mid_rst_no_output", {79'd0, bad}, 80'd0);
        start_job(vecs[3].ct, vecs[3].k);
        wait_done("post_rst", vecs[3].pt);
        release_out();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
